sd_decimator: RTL and testbench
===============================

SD_DECIMATOR -- requirements
Module: sd_decimator

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12, meaning system clocks per PDM bit period (legal range 4..255, even).
REQ-002 SHALL have parameter DEC_LOG2, default 7, meaning log2 of PDM bits per output sample (legal range 4..12).
REQ-003 SHALL have port CLK_24MHZ  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port pdm_i  input  1  1-bit sigma-delta bitstream, asynchronous to CLK_24MHZ.
REQ-006 SHALL have port bit_clk_o  output  1  bit clock driven to the external modulator.
REQ-007 SHALL have port sample_o  output  8  unsigned decimated PCM sample, 0 = all zeros, 255 = all ones.
REQ-008 SHALL have port sample_valid_o  output  1  one-cycle strobe marking a new sample_o.

Function
REQ-009 SHALL pass pdm_i through a 2-flop synchronizer; only the second flop output (pdm_s) is used internally.
REQ-010 SHALL run divider div_cnt counting 0..CLK_DIV-1, then wrap to 0.
REQ-011 SHALL assert internal strobe bit_stb on the cycle div_cnt == CLK_DIV-1.
REQ-012 SHALL drive bit_clk_o registered: high while div_cnt < CLK_DIV/2, low otherwise (50% duty).
REQ-013 SHALL, on each bit_stb, sample pdm_s and add it to ones accumulator acc (DEC_LOG2+1 bits, no overflow possible).
REQ-014 SHALL count strobes in bit_cnt (DEC_LOG2 bits), 0..2^DEC_LOG2-1, wrapping to 0.
REQ-015 SHALL define window end as bit_stb with bit_cnt == 2^DEC_LOG2-1; the total v = acc + pdm_s includes that last bit.
REQ-016 SHALL scale v to 8 bits: DEC_LOG2 <= 8 -> v << (8-DEC_LOG2); DEC_LOG2 > 8 -> v >> (DEC_LOG2-8); then saturate results > 255 to 255.
REQ-017 SHALL, at window end, clear acc to 0 on the same edge (next window starts empty, no bits lost or double-counted).
REQ-018 SHALL implement a two-state FSM: FLUSH (reset state) and RUN.
REQ-019 SHALL, in FLUSH, discard the window result: no sample_o update, no valid; go to RUN at window end.
REQ-020 SHALL, in RUN at window end, register the scaled value into sample_o and set sample_valid_o high for exactly one cycle (the next cycle).
REQ-021 SHALL hold sample_o stable between valid strobes.
REQ-022 SHALL make the output period exactly CLK_DIV * 2^DEC_LOG2 cycles, which is 1536 at defaults (15.625 kHz at 24 MHz).
REQ-023 SHALL have no back-pressure: each sample is presented once, and the consumer must capture it on the valid strobe.

Reset
REQ-024 SHALL, while RST is high, asynchronously force all of the following: synchronizer flops 0, div_cnt 0, bit_cnt 0, acc 0, state FLUSH, bit_clk_o 0, sample_o 0, sample_valid_o 0.
REQ-025 SHALL, when RST is asserted mid-window or mid-strobe, discard the partial window, and after release restart from FLUSH with a full discarded window.
REQ-026 SHALL, after RST release, produce the first bit_stb on the 12th rising edge and the first sample_valid_o 3073 edges after release (defaults).

Verification
REQ-027 SHALL cover: pdm_i held 1 -> first valid at edge 3073 with sample_o 255, then every 1536 cycles 255.
REQ-028 SHALL cover: pdm_i held 0 -> every valid carries sample_o 0; bit_clk_o toggles with period 12, high 6 cycles.
REQ-029 SHALL cover: pdm_i alternating 1,0 per bit period (aligned to bit_clk_o) -> sample_o 128 every valid.
REQ-030 SHALL cover: 96 ones then 32 zeros per window -> sample_o 192; DEC_LOG2=10 build with all ones -> 255 (saturation from 256).
REQ-031 SHALL cover: RST pulsed at cycle 2000 of a RUN window -> sample_o 0 immediately, no valid in the following 3072 cycles, and correct value at edge 3073 after release.
REQ-032 SHALL cover: pdm_i toggled off bit_clk_o edges (async jitter) -> no X propagation, and every sample matches a reference ones-count of pdm_s at strobes.

Source files
------------

// File: rtl/sd_decimator.sv
// rtl/sd_decimator.sv - 1-bit sigma-delta bitstream to 8-bit PCM decimator (divider, ones counter, scaler)
module sd_decimator #(
    parameter int CLK_DIV  = 12,
    parameter int DEC_LOG2 = 7
) (
    input  logic       CLK_24MHZ,
    input  logic       RST,
    input  logic       pdm_i,
    output logic       bit_clk_o,
    output logic [7:0] sample_o,
    output logic       sample_valid_o
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int ACC_W  = DEC_LOG2 + 1;
    localparam int WIDE_W = ACC_W + 8;
    localparam int SHL    = (DEC_LOG2 <= 8) ? (8 - DEC_LOG2) : 0;
    localparam int SHR    = (DEC_LOG2 > 8) ? (DEC_LOG2 - 8) : 0;

    typedef enum logic {FLUSH, RUN} state_t;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [DEC_LOG2-1:0] bit_cnt_q, bit_cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    state_t              state_q, state_d;
    logic                bit_clk_q, bit_clk_d;
    logic [7:0]          sample_q, sample_d;
    logic                valid_q, valid_d;

    logic                bit_stb;
    logic                win_end;
    logic [ACC_W-1:0]    v;
    logic [WIDE_W-1:0]   wide;
    logic [7:0]          scaled;

    always_comb begin
        sync1_d   = pdm_i;
        sync2_d   = sync1_q;
        bit_stb   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = bit_stb ? '0 : div_cnt_q + 1'b1;
        bit_clk_d = (div_cnt_d < DIV_W'(CLK_DIV / 2));
        win_end   = bit_stb && (bit_cnt_q == '1);
        bit_cnt_d = bit_stb ? bit_cnt_q + 1'b1 : bit_cnt_q;

        // v already includes the bit sampled on the closing strobe
        v = acc_q + ACC_W'(sync2_q);
        acc_d = acc_q;
        if (bit_stb) begin
            acc_d = win_end ? '0 : v;
        end

        wide   = (WIDE_W'(v) << SHL) >> SHR;
        scaled = (wide > WIDE_W'(255)) ? 8'hFF : wide[7:0];

        state_d  = state_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (win_end) begin
            if (state_q == FLUSH) begin
                state_d = RUN;
            end else begin
                sample_d = scaled;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_24MHZ or posedge RST) begin
        if (RST) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            acc_q     <= '0;
            state_q   <= FLUSH;
            bit_clk_q <= 1'b0;
            sample_q  <= 8'd0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
            bit_clk_q <= bit_clk_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
        end
    end

    assign bit_clk_o      = bit_clk_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_sd_decimator.sv
// tb/tb_sd_decimator.sv - directed bench for sd_decimator with immediate-assertion checks
`timescale 1ns/1ps
module tb_sd_decimator;

    localparam int M_ONES = 0, M_ZEROS = 1, M_ALT = 2, M_9632 = 3, M_JIT = 4;

    logic       clk;
    logic       rst;
    logic       pdm_i;
    logic       bit_clk_o;
    logic [7:0] sample_o;
    logic       sample_valid_o;

    logic       pdm10;
    logic       bit_clk10;
    logic [7:0] sample10;
    logic       valid10;

    int total = 0;
    int bad   = 0;
    int mode  = M_ONES;
    int pos   = 0;
    int vcnt  = 0;

    int edge_n = 0;
    logic m1 = 1'b0, m2 = 1'b0;
    int acc_m = 0;
    int exp_q[$];

    sd_decimator dut (
        .CLK_24MHZ      (clk),
        .RST            (rst),
        .pdm_i          (pdm_i),
        .bit_clk_o      (bit_clk_o),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o)
    );

    sd_decimator #(.CLK_DIV(12), .DEC_LOG2(10)) dut10 (
        .CLK_24MHZ      (clk),
        .RST            (rst),
        .pdm_i          (pdm10),
        .bit_clk_o      (bit_clk10),
        .sample_o       (sample10),
        .sample_valid_o (valid10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pat(int m, int idx);
        case (m)
            M_ONES:  return 1'b1;
            M_ZEROS: return 1'b0;
            M_ALT:   return idx[0] ? 1'b0 : 1'b1;
            M_9632:  return ((idx % 128) < 96) ? 1'b1 : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // Stimulus driver: bit-period-aligned patterns, or random changes between clock edges
    initial begin
        int off;
        pdm_i = 1'b1;
        forever begin
            @(posedge clk);
            if (mode == M_JIT) begin
                off = $urandom_range(1, 8);
                if (off >= 5) off = off + 1;
                #(off);
                pdm_i = 1'($urandom_range(0, 1));
            end else begin
                #1;
                pdm_i = pat(mode, edge_n / 12);
            end
        end
    end

    // Reference ones-count: own synchronizer copy, strobe every 12th edge, 128 strobes per window
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_n <= 0;
            m1     <= 1'b0;
            m2     <= 1'b0;
            acc_m  <= 0;
            exp_q.delete();
        end else begin
            int n, j, v;
            n = edge_n + 1;
            edge_n <= n;
            m1 <= pdm_i;
            m2 <= m1;
            if (n % 12 == 0) begin
                j = n / 12;
                v = acc_m + int'(m2);
                if (j % 128 == 0) begin
                    acc_m <= 0;
                    if (j > 128) exp_q.push_back((v * 2 > 255) ? 255 : v * 2);
                end else begin
                    acc_m <= v;
                end
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            pos++;
            if (sample_valid_o === 1'b1) vcnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pos  = 0;
        vcnt = 0;
    endtask

    initial begin
        int hi;
        int got;
        rst   = 1'b1;
        pdm10 = 1'b1;
        #1;
        check("reset_sample", 32'(sample_o), 0);
        check("reset_valid", 32'(sample_valid_o), 0);
        check("reset_bitclk", 32'(bit_clk_o), 0);

        // all ones
        mode = M_ONES;
        do_reset();
        tick(3071);
        check("ones_no_valid_before_3073", 32'(vcnt), 0);
        tick(1);
        check("ones_first_valid", 32'(sample_valid_o), 1);
        check("ones_first_sample", 32'(sample_o), 255);
        vcnt = 0;
        tick(1);
        check("ones_valid_one_cycle", 32'(sample_valid_o), 0);
        check("ones_sample_held", 32'(sample_o), 255);
        tick(1535);
        check("ones_period_valid", 32'(sample_valid_o), 1);
        check("ones_period_count", 32'(vcnt), 1);
        check("ones_second_sample", 32'(sample_o), 255);

        // all zeros plus bit clock shape
        mode = M_ZEROS;
        do_reset();
        tick(1);
        check("bitclk_after_edge1", 32'(bit_clk_o), 1);
        tick(10);
        check("bitclk_after_edge11", 32'(bit_clk_o), 0);
        hi = 0;
        for (int n = 12; n < 36; n++) begin
            tick(1);
            if (bit_clk_o === 1'b1) hi++;
            check("bitclk_phase", 32'(bit_clk_o), ((n - 12) % 12 < 6) ? 1 : 0);
        end
        check("bitclk_high_count", 32'(hi), 12);
        tick(3072 - pos);
        check("zeros_valid", 32'(sample_valid_o), 1);
        check("zeros_sample", 32'(sample_o), 0);
        tick(1536);
        check("zeros_valid2", 32'(sample_valid_o), 1);
        check("zeros_sample2", 32'(sample_o), 0);

        // alternating 1,0 per bit period
        mode = M_ALT;
        do_reset();
        tick(3072);
        check("alt_valid", 32'(sample_valid_o), 1);
        check("alt_sample", 32'(sample_o), 128);
        tick(1536);
        check("alt_sample2", 32'(sample_o), 128);

        // 96 ones then 32 zeros
        mode = M_9632;
        do_reset();
        tick(3072);
        check("w9632_valid", 32'(sample_valid_o), 1);
        check("w9632_sample", 32'(sample_o), 192);
        tick(1536);
        check("w9632_sample2", 32'(sample_o), 192);

        // reset 2000 cycles into a RUN window
        tick(2000);
        rst = 1'b1;
        #1;
        check("midrst_sample_cleared", 32'(sample_o), 0);
        check("midrst_valid_low", 32'(sample_valid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        pos  = 0;
        vcnt = 0;
        tick(3071);
        check("midrst_no_valid", 32'(vcnt), 0);
        check("midrst_sample_still0", 32'(sample_o), 0);
        tick(1);
        check("midrst_valid", 32'(sample_valid_o), 1);
        check("midrst_sample", 32'(sample_o), 192);

        // DEC_LOG2=10, all ones saturates 256 to 255
        mode = M_ONES;
        do_reset();
        got = 0;
        for (int n = 1; n < 24576; n++) begin
            @(negedge clk);
            if (valid10 === 1'b1) got++;
        end
        check("dec10_no_early_valid", 32'(got), 0);
        @(negedge clk);
        check("dec10_valid", 32'(valid10), 1);
        check("dec10_saturated", 32'(sample10), 255);

        // asynchronous jitter against the reference count
        mode = M_JIT;
        do_reset();
        got = 0;
        for (int n = 0; n < 3072 + 2 * 1536 + 4; n++) begin
            @(negedge clk);
            check("jit_no_x", 32'($isunknown({sample_o, sample_valid_o, bit_clk_o})), 0);
            if (sample_valid_o === 1'b1) begin
                got++;
                if (exp_q.size() == 0) begin
                    check("jit_expected_available", 0, 1);
                end else begin
                    check("jit_sample", 32'(sample_o), 32'(exp_q.pop_front()));
                end
            end
        end
        check("jit_valid_count", 32'(got), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
